// File: rtl/noc_vc_scheduler_pkg.sv
// Shared router scheduling types and the rotating-priority search used by the
// round-robin arbiters.
package noc_vc_scheduler_pkg;

    localparam int unsigned NocChannels  = 2;
    localparam int unsigned NocFlitWidth = 64;
    localparam int unsigned MaxChannels  = 8;

    typedef enum logic {StIdle, StLocked} sched_state_e;

    // First set request at or after ptr, wrapping modulo n; MaxChannels means none.
    function automatic int unsigned rr_first(input logic [MaxChannels-1:0] req,
                                             input int unsigned ptr,
                                             input int unsigned n);
        int unsigned idx;
        rr_first = MaxChannels;
        for (int unsigned i = 0; i < MaxChannels; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (i < n && rr_first == MaxChannels && req[idx[2:0]]) rr_first = idx;
        end
    endfunction

endpackage

// File: rtl/noc_round_robin_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// after the pointer.
module noc_round_robin_arbiter
    import noc_vc_scheduler_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned PTR_WIDTH = 1
) (
    input  logic [CHANNELS-1:0]  req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [CHANNELS-1:0]  grant
);

    logic [MaxChannels-1:0] req_ext;
    int unsigned            win;

    always_comb begin
        req_ext                 = '0;
        req_ext[CHANNELS-1:0]   = req;
        win                     = rr_first(req_ext, 32'(ptr), CHANNELS);
        grant                   = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            grant[c] = (win == c);
        end
    end

endmodule

// File: rtl/noc_vc_scheduler.sv
// Packet-atomic round-robin VC scheduler feeding a one-entry registered output
// slice; a VC keeps the grant from head to tail flit.
module noc_vc_scheduler
    import noc_vc_scheduler_pkg::*;
#(
    parameter  int unsigned CHANNELS   = NocChannels,
    parameter  int unsigned FLIT_WIDTH = NocFlitWidth,
    localparam int unsigned VC_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_clear,
    input  logic [CHANNELS-1:0]                 i_valid,
    output logic [CHANNELS-1:0]                 o_ready,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] i_flit,
    input  logic [CHANNELS-1:0]                 i_tail,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [FLIT_WIDTH-1:0]               o_flit,
    output logic [VC_WIDTH-1:0]                 o_vc,
    output logic                                o_locked
);

    sched_state_e            state_q, state_d;
    logic [VC_WIDTH-1:0]     ptr_q, ptr_d;
    logic [VC_WIDTH-1:0]     lock_vc_q, lock_vc_d;
    logic                    valid_q, valid_d;
    logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
    logic [VC_WIDTH-1:0]     vc_q, vc_d;

    logic [CHANNELS-1:0]     arb_grant, lock_grant, grant;
    logic [VC_WIDTH-1:0]     acc_vc;
    logic                    load, accept;

    noc_round_robin_arbiter #(
        .CHANNELS  (CHANNELS),
        .PTR_WIDTH (VC_WIDTH)
    ) u_arb (
        .req   (i_valid),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    always_comb begin
        load = !valid_q || i_ready;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            lock_grant[c] = (lock_vc_q == VC_WIDTH'(c));
        end
        grant = (state_q == StLocked) ? lock_grant : arb_grant;
        // Gating with rst_n keeps upstream FIFOs from popping while in reset.
        o_ready = (load && !i_clear && rst_n) ? grant : '0;
        accept  = |(i_valid & o_ready);
        acc_vc  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (grant[c]) acc_vc = VC_WIDTH'(c);
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_vc_d = lock_vc_q;
        valid_d   = valid_q;
        flit_d    = flit_q;
        vc_d      = vc_q;
        if (i_clear) begin
            valid_d = 1'b0;
            state_d = StIdle;
            ptr_d   = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            flit_d  = i_flit[acc_vc];
            vc_d    = acc_vc;
            if (i_tail[acc_vc]) begin
                state_d = StIdle;
                ptr_d   = (acc_vc == VC_WIDTH'(CHANNELS - 1)) ? '0 : acc_vc + 1'b1;
            end else begin
                state_d   = StLocked;
                lock_vc_d = acc_vc;
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            lock_vc_q <= '0;
            valid_q   <= 1'b0;
            flit_q    <= '0;
            vc_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_vc_q <= lock_vc_d;
            valid_q   <= valid_d;
            flit_q    <= flit_d;
            vc_q      <= vc_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_flit   = flit_q;
    assign o_vc     = vc_q;
    assign o_locked = (state_q == StLocked);

endmodule

// File: tb/tb_noc_vc_scheduler.sv
// Directed bench for noc_vc_scheduler: a 4-VC instance for packet, backpressure,
// clear and reset behaviour, plus a 3-VC instance for pointer wrap.
module tb_noc_vc_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic             clear4;
    logic [3:0]       valid4, ready4, tail4;
    logic [3:0][63:0] flit4;
    logic             ovalid4, iready4, locked4;
    logic [63:0]      oflit4;
    logic [1:0]       ovc4;

    // 3-channel instance
    logic             clear3;
    logic [2:0]       valid3, ready3, tail3;
    logic [2:0][63:0] flit3;
    logic             ovalid3, iready3, locked3;
    logic [63:0]      oflit3;
    logic [1:0]       ovc3;

    noc_vc_scheduler #(.CHANNELS(4), .FLIT_WIDTH(64)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (clear4),
        .i_valid  (valid4),
        .o_ready  (ready4),
        .i_flit   (flit4),
        .i_tail   (tail4),
        .o_valid  (ovalid4),
        .i_ready  (iready4),
        .o_flit   (oflit4),
        .o_vc     (ovc4),
        .o_locked (locked4)
    );

    noc_vc_scheduler #(.CHANNELS(3), .FLIT_WIDTH(64)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (clear3),
        .i_valid  (valid3),
        .o_ready  (ready3),
        .i_flit   (flit3),
        .i_tail   (tail3),
        .o_valid  (ovalid3),
        .i_ready  (iready3),
        .o_flit   (oflit3),
        .o_vc     (ovc3),
        .o_locked (locked3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fv(input int vc, input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(vc * 256 + k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear4 = 0; valid4 = '0; tail4 = '0; flit4 = '0; iready4 = 1;
        clear3 = 0; valid3 = '0; tail3 = '0; flit3 = '0; iready3 = 1;
        valid4 = 4'b0001;
        #12;
        check_eq("rst_ovalid", 64'(ovalid4), 64'd0);
        check_eq("rst_oflit", oflit4, 64'd0);
        check_eq("rst_ovc", 64'(ovc4), 64'd0);
        check_eq("rst_locked", 64'(locked4), 64'd0);
        check_eq("rst_oready", 64'(ready4), 64'd0);
        #5 rst_n = 1;
        tick();

        // Single VC0 4-flit packet
        valid4 = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            flit4[0] = fv(0, k);
            tail4[0] = (k == 3);
            #1;
            check_eq("t1_oready", 64'(ready4), 64'b0001);
            tick();
            check_eq("t1_ovalid", 64'(ovalid4), 64'd1);
            check_eq("t1_oflit", oflit4, fv(0, k));
            check_eq("t1_ovc", 64'(ovc4), 64'd0);
            check_eq("t1_locked", 64'(locked4), 64'(k != 3));
        end
        valid4 = '0;
        tick();
        check_eq("t1_drain", 64'(ovalid4), 64'd0);

        // Clear to bring pointer back to 0 (it sits at 1 now)
        clear4 = 1;
        tick();
        clear4 = 0;

        // Interleave guard: VC0 3 flits with one bubble, VC1 2 flits waiting
        valid4 = 4'b0011; flit4[0] = fv(0, 0); tail4[0] = 0; flit4[1] = fv(1, 0); tail4[1] = 0;
        #1;
        check_eq("t2_grant_vc0", 64'(ready4), 64'b0001);
        tick();
        check_eq("t2_f0", oflit4, fv(0, 0));
        check_eq("t2_f0_locked", 64'(locked4), 64'd1);
        valid4 = 4'b0010;
        #1;
        check_eq("t2_bubble_vc1_wait", 64'(ready4 & 4'b1110), 64'd0);
        tick();
        check_eq("t2_bubble_ovalid", 64'(ovalid4), 64'd0);
        check_eq("t2_bubble_locked", 64'(locked4), 64'd1);
        valid4 = 4'b0011; flit4[0] = fv(0, 1);
        #1;
        check_eq("t2_f1_vc1_wait", 64'(ready4 & 4'b1110), 64'd0);
        tick();
        check_eq("t2_f1", oflit4, fv(0, 1));
        flit4[0] = fv(0, 2); tail4[0] = 1;
        tick();
        check_eq("t2_f2", oflit4, fv(0, 2));
        check_eq("t2_f2_locked", 64'(locked4), 64'd0);
        valid4 = 4'b0010;
        #1;
        check_eq("t2_grant_vc1", 64'(ready4), 64'b0010);
        tick();
        check_eq("t2_vc1_f0", oflit4, fv(1, 0));
        check_eq("t2_vc1_vc", 64'(ovc4), 64'd1);
        flit4[1] = fv(1, 1); tail4[1] = 1;
        tick();
        check_eq("t2_vc1_f1", oflit4, fv(1, 1));
        check_eq("t2_vc1_unlock", 64'(locked4), 64'd0);

        // Backpressure mid-packet on VC2 (pointer now 2)
        valid4 = 4'b0100; flit4[2] = fv(2, 0); tail4[2] = 0;
        tick();
        check_eq("t3_f0", oflit4, fv(2, 0));
        flit4[2] = fv(2, 1); iready4 = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t3_bp_oready", 64'(ready4), 64'd0);
            tick();
            check_eq("t3_bp_hold_flit", oflit4, fv(2, 0));
            check_eq("t3_bp_hold_vc", 64'(ovc4), 64'd2);
            check_eq("t3_bp_hold_valid", 64'(ovalid4), 64'd1);
        end
        iready4 = 1;
        #1;
        check_eq("t3_release_oready", 64'(ready4), 64'b0100);
        tick();
        check_eq("t3_f1", oflit4, fv(2, 1));
        check_eq("t3_locked", 64'(locked4), 64'd1);

        // Clear while locked on VC2 with the slice full
        iready4 = 0; clear4 = 1; valid4 = 4'b1110; flit4[1] = fv(1, 5); tail4[1] = 1;
        flit4[3] = fv(3, 5); tail4[3] = 1;
        #1;
        check_eq("t5_clear_oready", 64'(ready4), 64'd0);
        tick();
        clear4 = 0; iready4 = 1;
        check_eq("t5_ovalid", 64'(ovalid4), 64'd0);
        check_eq("t5_locked", 64'(locked4), 64'd0);
        valid4 = 4'b1010;
        #1;
        check_eq("t5_ptr0_grant_vc1", 64'(ready4), 64'b0010);
        tick();
        check_eq("t5_vc1_out", oflit4, fv(1, 5));

        // Fairness: both instances stream single-flit packets from every VC
        clear4 = 1;
        tick();
        clear4 = 0;
        valid4 = 4'b1111; tail4 = 4'b1111;
        valid3 = 3'b111;  tail3 = 3'b111;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 4; c++) flit4[c] = fv(c, k);
            for (int c = 0; c < 3; c++) flit3[c] = fv(c, k);
            tick();
            check_eq("t4_vc4", 64'(ovc4), 64'(k % 4));
            check_eq("t4_flit4", oflit4, fv(k % 4, k));
            check_eq("t4_valid4", 64'(ovalid4), 64'd1);
            check_eq("t4_vc3", 64'(ovc3), 64'(k % 3));
            check_eq("t4_flit3", oflit3, fv(k % 3, k));
        end
        valid3 = '0;

        // Async reset mid-packet: VC1 single flit (ptr -> 2), then VC3 head locks
        valid4 = 4'b0010; flit4[1] = fv(1, 9);
        tick();
        valid4 = 4'b1000; flit4[3] = fv(3, 9); tail4[3] = 0;
        tick();
        check_eq("t6_pre_vc", 64'(ovc4), 64'd3);
        check_eq("t6_pre_locked", 64'(locked4), 64'd1);
        #2 rst_n = 0;
        #1;
        check_eq("t6_rst_ovalid", 64'(ovalid4), 64'd0);
        check_eq("t6_rst_locked", 64'(locked4), 64'd0);
        check_eq("t6_rst_ovc", 64'(ovc4), 64'd0);
        check_eq("t6_rst_oready", 64'(ready4), 64'd0);
        #1 rst_n = 1;
        valid4 = 4'b1010; flit4[1] = fv(1, 10); tail4 = 4'b1111;
        #1;
        check_eq("t6_post_grant_vc1", 64'(ready4), 64'b0010);
        tick();
        check_eq("t6_post_flit", oflit4, fv(1, 10));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
